multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 64-bit RV64 datapath: one shared ALU, one unified memory port, register file, immediate generator.
- Drives per-state control strobes for R-type, ld, sd and beq, and waits on a memory ready handshake.
- Holds an unsupported opcode in a sticky HALT and counts retired instructions.
- Sits between the top level and the datapath, replacing the single-cycle combinational control decode.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.
- MAX_WAIT, 15, memory wait cycles tolerated in FETCH/MEM before HALT (bus timeout); 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  enable instruction sequencing
- opcode  input  7  inst[6:0] from instruction register; valid from DECODE onward
- zero  input  1  ALU zero flag; sampled in EXEC
- mem_ready  input  1  memory completes current access this cycle
- IRWrite  output  1  load instruction register and OldPC (FETCH)
- PCWrite  output  1  update PC
- PCSrc  output  1  0: PC+4, 1: OldPC+imm
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IorD  output  1  0: address = PC, 1: address = ALU result
- ALUSrc  output  1  0: rs2, 1: imm
- ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
- RegWrite  output  1  write rd
- MemtoReg  output  1  0: ALU result, 1: memory data
- busy  output  1  state != IDLE and != HALT
- halted  output  1  in HALT
- instret  output  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- State register, op_q, wait_cnt and instret are reset asynchronously; reset wins over every other event.
- Outputs are decoded from state, op_q and the mem_ready/zero inputs as listed below. Every strobe not listed for a state is 0.
- Reset: state=IDLE, op_q=0, wait_cnt=0, instret=0. All strobes 0, busy=0, halted=0. Reset mid-instruction abandons it with no write.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - MemRead=1, IorD=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1 (PCSrc=0), go to DECODE.
  - Otherwise stay with wait_cnt++.
- DECODE: op_q <= opcode.
  - 0110011, 0000011, 0100011, 1100011 -> EXEC.
  - Any other opcode -> HALT.
- EXEC:
  - R-type: ALUSrc=0, ALUOp=10 -> WB.
  - ld/sd: ALUSrc=1, ALUOp=00 -> MEM.
  - beq: ALUSrc=0, ALUOp=01, PCSrc=1, PCWrite=zero; instruction retires.
- MEM:
  - IorD=1; ld: MemRead=1; sd: MemWrite=1.
  - Strobes are held until mem_ready=1.
  - On mem_ready, ld -> WB; sd retires.
  - Otherwise wait_cnt++.
- WB:
  - RegWrite=1; MemtoReg=1 for ld, 0 for R-type.
  - ALU result and memory data are held in datapath registers.
  - Instruction retires.
- Retire: instret += 1, wrapping modulo 2^CNT_W. Next state is FETCH if run=1, else IDLE. Deasserting run mid-instruction does not stop it; the stop takes effect only at retire.
- Latency per instruction, with zero memory wait:
  - R-type: 4 cycles.
  - ld: 5 cycles.
  - sd: 4 cycles.
  - beq: 3 cycles.
- Each memory wait cycle adds one cycle.
- wait_cnt clears on entering FETCH or MEM.
- Timeout: with MAX_WAIT>0, wait_cnt==MAX_WAIT and mem_ready=0 -> HALT. No write or PC update occurs. mem_ready in the same cycle as the timeout takes priority (the access completes).
- HALT: sticky until rst_n=0; all strobes 0, halted=1, instret frozen.
- rd==x0 write suppression belongs to the register file; the controller still asserts RegWrite.

Test Plan:
- Reset, run=1, opcode=0110011, mem_ready=1 -> FETCH, DECODE, EXEC (ALUOp=10), WB (RegWrite=1, MemtoReg=0), FETCH. instret=1 after 4 cycles.
- ld with mem_ready low for 3 MEM cycles -> MemRead and IorD held for 4 MEM cycles, then WB with MemtoReg=1. Total 8 cycles, instret increments once.
- beq with zero=1 -> PCWrite=1, PCSrc=1 in EXEC. With zero=0 -> PCWrite=0 in EXEC. Both take 3 cycles.
- sd -> MemWrite=1 only in MEM, RegWrite never asserted, 4 cycles.
- opcode=0010011 -> DECODE, then HALT. halted=1, all strobes 0 for 20 cycles, instret unchanged; rst_n pulse -> IDLE.
- MAX_WAIT=15, mem_ready stuck 0 in FETCH -> HALT after 16 FETCH cycles, IRWrite never asserted. Separately, run dropped during EXEC -> instruction completes, then IDLE.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64 sequencer: drives per-state datapath strobes for R-type, ld, sd and beq,
// waits on the memory ready handshake, halts on unsupported opcodes or bus timeout.
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic              timeout;

    // mem_ready in the timeout cycle still completes the access
    assign timeout = (MAX_WAIT > 0) && (wait_cnt == WAIT_W'(MAX_WAIT)) && !mem_ready;

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_LD, OP_SD, OP_BEQ: state_d = S_EXEC;
                    default:                    state_d = S_HALT;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        ALUOp   = 2'b10;
                        state_d = S_WB;
                    end
                    OP_LD, OP_SD: begin
                        ALUSrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        ALUOp   = 2'b01;
                        PCSrc   = 1'b1;
                        PCWrite = zero;
                        retire  = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = (op_q == OP_LD);
                MemWrite = (op_q == OP_SD);
                if (mem_ready) begin
                    if (op_q == OP_LD) state_d = S_WB;
                    else               retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (op_q == OP_LD);
                retire   = 1'b1;
            end
            default: state_d = S_HALT;
        endcase
        // a stop request only takes effect at an instruction boundary
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted = (state_q == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM))
                wait_cnt <= '0;
            else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
            if (retire) instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle strobe vectors and instret against hand-computed values.
module tb_multicycle_ctrl;

    logic        clk, rst_n, run, zero, mem_ready;
    logic [6:0]  opcode;
    logic        IRWrite, PCWrite, PCSrc, MemRead, MemWrite, IorD, ALUSrc;
    logic [1:0]  ALUOp;
    logic        RegWrite, MemtoReg, busy, halted;
    logic [31:0] instret;
    logic [12:0] obs;
    int          n_chk, n_err;

    multicycle_ctrl #(.CNT_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .busy(busy),
        .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    // {IRWrite,PCWrite,PCSrc,MemRead,MemWrite,IorD,ALUSrc,ALUOp[1:0],RegWrite,MemtoReg,busy,halted}
    assign obs = {IRWrite, PCWrite, PCSrc, MemRead, MemWrite, IorD, ALUSrc, ALUOp,
                  RegWrite, MemtoReg, busy, halted};

    localparam logic [12:0] V_IDLE  = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] V_FWAIT = 13'b0_0_0_1_0_0_0_00_0_0_1_0;
    localparam logic [12:0] V_FRDY  = 13'b1_1_0_1_0_0_0_00_0_0_1_0;
    localparam logic [12:0] V_DEC   = 13'b0_0_0_0_0_0_0_00_0_0_1_0;
    localparam logic [12:0] V_EXR   = 13'b0_0_0_0_0_0_0_10_0_0_1_0;
    localparam logic [12:0] V_EXLS  = 13'b0_0_0_0_0_0_1_00_0_0_1_0;
    localparam logic [12:0] V_BEQ1  = 13'b0_1_1_0_0_0_0_01_0_0_1_0;
    localparam logic [12:0] V_BEQ0  = 13'b0_0_1_0_0_0_0_01_0_0_1_0;
    localparam logic [12:0] V_MEMLD = 13'b0_0_0_1_0_1_0_00_0_0_1_0;
    localparam logic [12:0] V_MEMSD = 13'b0_0_0_0_1_1_0_00_0_0_1_0;
    localparam logic [12:0] V_WBR   = 13'b0_0_0_0_0_0_0_00_1_0_1_0;
    localparam logic [12:0] V_WBLD  = 13'b0_0_0_0_0_0_0_00_1_1_1_0;
    localparam logic [12:0] V_HALT  = 13'b0_0_0_0_0_0_0_00_0_0_0_1;

    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011, OP_ADDI = 7'b0010011;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs just after negedge, sample before the next posedge
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [6:0] op,
                       input logic [12:0] e);
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        #4;
        chk(tag, 64'(obs), 64'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        clk = 0; rst_n = 0; run = 0; zero = 0; mem_ready = 0; opcode = '0;
        @(negedge clk);
        chk("rst_vec", 64'(obs), 64'(V_IDLE));
        chk("rst_instret", 64'(instret), 64'd0);
        rst_n = 1;
        cyc("idle_hold", 1, 0, '0, V_IDLE);

        // R-type, zero wait
        run = 1;
        cyc("r_idle", 1, 0, OP_R, V_IDLE);
        cyc("r_fetch", 1, 0, OP_R, V_FRDY);
        cyc("r_dec", 1, 0, OP_R, V_DEC);
        cyc("r_exec", 1, 0, OP_R, V_EXR);
        cyc("r_wb", 1, 0, OP_R, V_WBR);
        chk("r_instret", 64'(instret), 64'd1);

        // ld with three memory wait cycles
        cyc("ld_fetch", 1, 0, OP_LD, V_FRDY);
        cyc("ld_dec", 1, 0, OP_LD, V_DEC);
        cyc("ld_exec", 1, 0, 7'h7f, V_EXLS);
        for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 0, 0, 7'h7f, V_MEMLD);
        chk("ld_mid_instret", 64'(instret), 64'd1);
        cyc("ld_mem_rdy", 1, 0, 7'h7f, V_MEMLD);
        cyc("ld_wb", 1, 0, 7'h7f, V_WBLD);
        chk("ld_instret", 64'(instret), 64'd2);

        // beq taken, then not taken with a 15-cycle fetch wait ending on ready at the limit
        cyc("beq1_fetch", 1, 0, OP_BEQ, V_FRDY);
        cyc("beq1_dec", 1, 0, OP_BEQ, V_DEC);
        cyc("beq1_exec", 1, 1, OP_BEQ, V_BEQ1);
        chk("beq1_instret", 64'(instret), 64'd3);
        for (int i = 0; i < 15; i++) cyc("beq0_fwait", 0, 0, OP_BEQ, V_FWAIT);
        cyc("beq0_fetch_limit", 1, 0, OP_BEQ, V_FRDY);
        cyc("beq0_dec", 1, 0, OP_BEQ, V_DEC);
        cyc("beq0_exec", 1, 0, OP_BEQ, V_BEQ0);
        chk("beq0_instret", 64'(instret), 64'd4);

        // sd
        cyc("sd_fetch", 1, 0, OP_SD, V_FRDY);
        cyc("sd_dec", 1, 0, OP_SD, V_DEC);
        cyc("sd_exec", 1, 0, OP_SD, V_EXLS);
        cyc("sd_mem", 1, 0, OP_SD, V_MEMSD);
        chk("sd_instret", 64'(instret), 64'd5);

        // run dropped during EXEC: instruction completes, then IDLE
        cyc("stop_fetch", 1, 0, OP_R, V_FRDY);
        cyc("stop_dec", 1, 0, OP_R, V_DEC);
        run = 0;
        cyc("stop_exec", 1, 0, OP_R, V_EXR);
        cyc("stop_wb", 1, 0, OP_R, V_WBR);
        cyc("stop_idle", 1, 0, OP_R, V_IDLE);
        cyc("stop_idle2", 1, 0, OP_R, V_IDLE);
        chk("stop_instret", 64'(instret), 64'd6);

        // fetch timeout: 16 FETCH cycles then HALT
        run = 1;
        cyc("to_idle", 0, 0, OP_R, V_IDLE);
        for (int i = 0; i < 16; i++) cyc("to_fwait", 0, 0, OP_R, V_FWAIT);
        cyc("to_halt", 1, 0, OP_R, V_HALT);
        cyc("to_halt_sticky", 1, 0, OP_R, V_HALT);
        chk("to_instret", 64'(instret), 64'd6);

        // reset pulse, then unsupported opcode halts
        rst_n = 0;
        #2;
        chk("rst_pulse_vec", 64'(obs), 64'(V_IDLE));
        chk("rst_pulse_instret", 64'(instret), 64'd0);
        @(negedge clk);
        rst_n = 1;
        cyc("ill_idle", 1, 0, OP_ADDI, V_IDLE);
        cyc("ill_fetch", 1, 0, OP_ADDI, V_FRDY);
        cyc("ill_dec", 1, 0, OP_ADDI, V_DEC);
        for (int i = 0; i < 20; i++) begin
            cyc("ill_halt", 1'(i), 1'(i >> 1), OP_R, V_HALT);
            chk("ill_instret", 64'(instret), 64'd0);
        end
        rst_n = 0;
        run = 0;
        #2;
        chk("ill_rst_vec", 64'(obs), 64'(V_IDLE));
        @(negedge clk);
        rst_n = 1;
        cyc("ill_after_rst", 1, 0, OP_R, V_IDLE);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
